// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB writeback stage and its select mux.
package wb_pkg;

    localparam int unsigned DW       = 32;
    localparam int unsigned RW       = 5;
    localparam int unsigned LINK_REG = 31;
    localparam int unsigned RD_MSB   = 15;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned RT_MSB   = 20;
    localparam int unsigned RT_LSB   = 16;

    typedef enum logic [1:0] {
        RUN,
        LOAD_WAIT,
        HALTED
    } wb_state_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc4;
        logic [DW-1:0] alu;
        logic          regdst;
        logic          jal;
        logic          memtoreg;
        logic          regwrite;
        logic          dren;
        logic          halt;
    } wb_req_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-side request, load return and register-file write/forward signals of the writeback stage.
// WB_RETIRE_COUNT_EN adds the retire_cnt signal.
interface writeback_stage_if;
    import wb_pkg::*;

    logic          mem_valid;
    logic [DW-1:0] mem_instr;
    logic [DW-1:0] mem_pc4;
    logic [DW-1:0] mem_alu;
    logic          mem_regdst;
    logic          mem_jal;
    logic          mem_memtoreg;
    logic          mem_regwrite;
    logic          mem_dren;
    logic          mem_halt;
    logic          dhit;
    logic [DW-1:0] dload;
    logic          mem_stall;
    logic          wb_wen;
    logic [RW-1:0] wb_wsel;
    logic [DW-1:0] wb_wdat;
    logic          wb_halt;
    logic          fwd_valid;
    logic [RW-1:0] fwd_sel;
    logic [DW-1:0] fwd_dat;
`ifdef WB_RETIRE_COUNT_EN
    logic [DW-1:0] retire_cnt;

    modport master (
        output mem_valid, mem_instr, mem_pc4, mem_alu, mem_regdst, mem_jal, mem_memtoreg,
               mem_regwrite, mem_dren, mem_halt, dhit, dload,
        input  mem_stall, wb_wen, wb_wsel, wb_wdat, wb_halt, fwd_valid, fwd_sel, fwd_dat,
               retire_cnt
    );

    modport slave (
        input  mem_valid, mem_instr, mem_pc4, mem_alu, mem_regdst, mem_jal, mem_memtoreg,
               mem_regwrite, mem_dren, mem_halt, dhit, dload,
        output mem_stall, wb_wen, wb_wsel, wb_wdat, wb_halt, fwd_valid, fwd_sel, fwd_dat,
               retire_cnt
    );
`else
    modport master (
        output mem_valid, mem_instr, mem_pc4, mem_alu, mem_regdst, mem_jal, mem_memtoreg,
               mem_regwrite, mem_dren, mem_halt, dhit, dload,
        input  mem_stall, wb_wen, wb_wsel, wb_wdat, wb_halt, fwd_valid, fwd_sel, fwd_dat
    );

    modport slave (
        input  mem_valid, mem_instr, mem_pc4, mem_alu, mem_regdst, mem_jal, mem_memtoreg,
               mem_regwrite, mem_dren, mem_halt, dhit, dload,
        output mem_stall, wb_wen, wb_wsel, wb_wdat, wb_halt, fwd_valid, fwd_sel, fwd_dat
    );
`endif

endinterface

// File: rtl/wb_select.sv
// Combinational destination/data/write-enable resolution for one MEM-stage request.
// Shared with the execute-stage bypass unit.
module wb_select
    import wb_pkg::*;
(
    input  wb_req_t       req,
    input  logic [DW-1:0] dload,
    output logic [RW-1:0] wsel,
    output logic [DW-1:0] wdat,
    output logic          wen
);

    always_comb begin
        wsel = req.instr[RT_MSB:RT_LSB];
        if (req.regdst) begin
            wsel = req.instr[RD_MSB:RD_LSB];
        end else if (req.jal) begin
            wsel = RW'(LINK_REG);
        end

        wdat = req.alu;
        if (req.jal) begin
            wdat = req.pc4;
        end else if (req.memtoreg) begin
            wdat = dload;
        end

        // Register 0 is hardwired, so writes to it are dropped here.
        wen = req.valid & req.regwrite & (wsel != '0);
    end

    logic unused_req;
    assign unused_req = ^{req.instr[31:21], req.instr[10:0], req.dren, req.halt};

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB latch: registers one register-file write per retired instruction, stalls MEM on
// outstanding loads and exposes a forwarding tap. WB_RETIRE_COUNT_EN adds a retire counter.
module writeback_stage
    import wb_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    writeback_stage_if.slave bus
);

    wb_req_t       req;
    wb_state_t     state_q, state_d;
    logic          stall;
    logic          capture;
    logic [RW-1:0] sel_wsel;
    logic [DW-1:0] sel_wdat;
    logic          sel_wen;
    logic          wen_q;
    logic [RW-1:0] wsel_q;
    logic [DW-1:0] wdat_q;
    logic          halt_q;

    always_comb begin
        req          = '0;
        req.valid    = bus.mem_valid;
        req.instr    = bus.mem_instr;
        req.pc4      = bus.mem_pc4;
        req.alu      = bus.mem_alu;
        req.regdst   = bus.mem_regdst;
        req.jal      = bus.mem_jal;
        req.memtoreg = bus.mem_memtoreg;
        req.regwrite = bus.mem_regwrite;
        req.dren     = bus.mem_dren;
        req.halt     = bus.mem_halt;
    end

    wb_select u_select (
        .req   (req),
        .dload (bus.dload),
        .wsel  (sel_wsel),
        .wdat  (sel_wdat),
        .wen   (sel_wen)
    );

    always_comb begin
        stall   = req.valid & req.dren & ~bus.dhit & (state_q != HALTED);
        capture = req.valid & ~stall & (state_q != HALTED);
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (capture && req.halt) begin
                    state_d = HALTED;
                end else if (stall) begin
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                // MEM holds its request stable, so capture here means dhit arrived.
                if (capture) begin
                    state_d = req.halt ? HALTED : RUN;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            wen_q   <= 1'b0;
            wsel_q  <= '0;
            wdat_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= capture & sel_wen;
            if (capture) begin
                wsel_q <= sel_wsel;
                wdat_q <= sel_wdat;
            end
            if (capture && req.halt) begin
                halt_q <= 1'b1;
            end
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [DW-1:0] cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= cnt_q + DW'(1);
        end
    end

    assign bus.retire_cnt = cnt_q;
`endif

    assign bus.mem_stall = stall;
    assign bus.wb_wen    = wen_q;
    assign bus.wb_wsel   = wsel_q;
    assign bus.wb_wdat   = wdat_q;
    assign bus.wb_halt   = halt_q;
    assign bus.fwd_valid = wen_q;
    assign bus.fwd_sel   = wsel_q;
    assign bus.fwd_dat   = wdat_q;

endmodule
